// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue circular instruction queue between fetch and decode.
// Optional macro FETCHQ_BYPASS_EN: an empty, unstalled queue forwards the incoming pair with 0-cycle latency.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst0_i,
    input  logic [31:0] inst1_i,
    input  logic [31:0] pc_i,
    input  logic        valid0_i,
    input  logic        valid1_i,
    output logic        ready_o,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic [31:0] inst0_o,
    output logic [31:0] inst1_o,
    output logic [31:0] pc0_o,
    output logic [31:0] pc1_o,
    output logic        valid0_o,
    output logic        valid1_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      NOP       = 32'h0000_0013;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       push_n, pop_n;
    logic             push_en, bypass;
    logic             q_valid0, q_valid1;
    entry_t           head0, head1;

    // Ready looks only at registered occupancy; a same-cycle pop earns no credit.
    assign ready_o  = (count_q <= READY_MAX);
    assign q_valid0 = (count_q >= CNT_W'(1));
    assign q_valid1 = (count_q >= CNT_W'(2));
    assign head0    = mem_q[head_q];
    assign head1    = mem_q[head_q + PTR_W'(1)];

`ifdef FETCHQ_BYPASS_EN
    assign bypass = valid0_i & (count_q == '0) & ~stall_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign push_en = valid0_i & ready_o & ~flush_i & ~bypass;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        push_n = 2'd0;
        pop_n  = 2'd0;
        if (push_en) begin
            push_n = valid1_i ? 2'd2 : 2'd1;
        end
        if (!stall_i && !flush_i) begin
            pop_n = {1'b0, q_valid0} + {1'b0, q_valid1};
        end
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        valid0_o = q_valid0;
        valid1_o = q_valid1;
        inst0_o  = q_valid0 ? head0.inst : NOP;
        pc0_o    = q_valid0 ? head0.pc   : 32'h0;
        inst1_o  = q_valid1 ? head1.inst : NOP;
        pc1_o    = q_valid1 ? head1.pc   : 32'h0;
`ifdef FETCHQ_BYPASS_EN
        if (bypass) begin
            valid0_o = 1'b1;
            valid1_o = valid1_i;
            inst0_o  = inst0_i;
            pc0_o    = pc_i;
            inst1_o  = valid1_i ? inst1_i : NOP;
            pc1_o    = valid1_i ? pc_i + 32'd4 : 32'h0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which entries are visible.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[tail_q] <= {inst0_i, pc_i};
            if (valid1_i) begin
                mem_q[tail_q + PTR_W'(1)] <= {inst1_i, pc_i + 32'd4};
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (default build): expected entries are queued when
// fetch stimulus is accepted and retired when decode takes them.
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] inst0_i, inst1_i, pc_i;
    logic        valid0_i, valid1_i, flush_i, stall_i;
    logic        ready_o, valid0_o, valid1_o;
    logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;

    entry_t sb[$];
    int     passed = 0;
    int     total  = 0;

    wire [130:0] obs = {ready_o, valid0_o, valid1_o, inst0_o, pc0_o, inst1_o, pc1_o};

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .inst0_i(inst0_i), .inst1_i(inst1_i), .pc_i(pc_i),
        .valid0_i(valid0_i), .valid1_i(valid1_i), .ready_o(ready_o),
        .flush_i(flush_i), .stall_i(stall_i),
        .inst0_o(inst0_o), .inst1_o(inst1_o), .pc0_o(pc0_o), .pc1_o(pc1_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o)
    );

    always #5 clk = ~clk;

    // Expected {ready, valid0, valid1, inst0, pc0, inst1, pc1} from the scoreboard contents.
    function automatic logic [130:0] exp_state();
        logic r, v0, v1;
        logic [31:0] i0, p0, i1, p1;
        r  = (sb.size() <= DEPTH - 2);
        v0 = (sb.size() >= 1);
        v1 = (sb.size() >= 2);
        i0 = v0 ? sb[0].inst : NOP;
        p0 = v0 ? sb[0].pc   : 32'h0;
        i1 = v1 ? sb[1].inst : NOP;
        p1 = v1 ? sb[1].pc   : 32'h0;
        return {r, v0, v1, i0, p0, i1, p1};
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge, return #1 after it.
    task automatic tick(input logic v0, input logic v1, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [31:0] pc,
                        input logic stall, input logic flush);
        int  npop;
        logic acc;
        valid0_i = v0; valid1_i = v1; inst0_i = i0; inst1_i = i1; pc_i = pc;
        stall_i = stall; flush_i = flush;
        acc  = v0 && (sb.size() <= DEPTH - 2);
        npop = stall ? 0 : ((sb.size() >= 2) ? 2 : sb.size());
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            for (int k = 0; k < npop; k++) void'(sb.pop_front());
            if (acc) begin
                sb.push_back('{inst: i0, pc: pc});
                if (v1) sb.push_back('{inst: i1, pc: pc + 32'd4});
            end
        end
        #1;
        valid0_i = 1'b0; valid1_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic idle(input logic stall);
        tick(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, stall, 1'b0);
    endtask

    task automatic test_reset();
        total++;
        if (obs !== exp_state()) $display("FAIL reset_state: got %h expected %h", obs, exp_state());
        else passed++;
        rst_i = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs !== exp_state()) $display("FAIL reset_release: got %h expected %h", obs, exp_state());
        else passed++;
    endtask

    task automatic test_basic_pair();
        tick(1'b1, 1'b1, 32'h00500093, 32'h00A00113, 32'h100, 1'b0, 1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL basic_out: got %h expected %h", obs, exp_state());
        else passed++;
        total++;
        if ({valid0_o, valid1_o, pc0_o, pc1_o} !== {2'b11, 32'h100, 32'h104})
            $display("FAIL basic_pcs: got %b%b %h %h expected 11 00000100 00000104",
                     valid0_o, valid1_o, pc0_o, pc1_o);
        else passed++;
        idle(1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL basic_drain: got %h expected %h", obs, exp_state());
        else passed++;
    endtask

    task automatic test_odd_issue();
        tick(1'b1, 1'b0, 32'h00100013, 32'hDEADBEEF, 32'h200, 1'b0, 1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL odd_single: got %h expected %h", obs, exp_state());
        else passed++;
        tick(1'b1, 1'b1, 32'h00200013, 32'h00300013, 32'h204, 1'b0, 1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL odd_pair: got %h expected %h", obs, exp_state());
        else passed++;
        idle(1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL odd_drain: got %h expected %h", obs, exp_state());
        else passed++;
    endtask

    task automatic test_stall_fill();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (ready_o !== exp_state()[130])
                $display("FAIL fill_ready_%0d: got %b expected %b", k, ready_o, exp_state()[130]);
            else passed++;
            tick(1'b1, 1'b1, 32'h1000 + 32'(2 * k), 32'h1001 + 32'(2 * k),
                 32'h300 + 32'(8 * k), 1'b1, 1'b0);
            total++;
            if (obs !== exp_state()) $display("FAIL fill_hold_%0d: got %h expected %h", k, obs, exp_state());
            else passed++;
        end
        total++;
        if (ready_o !== 1'b0) $display("FAIL fill_full: got ready %b expected 0", ready_o);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            total++;
            if (obs !== exp_state()) $display("FAIL fill_drain_%0d: got %h expected %h", k, obs, exp_state());
            else passed++;
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            tick(1'b1, 1'b1, 32'h2000 + 32'(2 * k), 32'h2001 + 32'(2 * k),
                 32'h400 + 32'(8 * k), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            total++;
            if (obs !== exp_state()) $display("FAIL wrap_pop_%0d: got %h expected %h", k, obs, exp_state());
            else passed++;
        end
        // Head now sits at index 6, so the next two pairs land in 6,7,0,1.
        for (int k = 0; k < 2; k++)
            tick(1'b1, 1'b1, 32'h3000 + 32'(2 * k), 32'h3001 + 32'(2 * k),
                 32'h500 + 32'(8 * k), 1'b1, 1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL wrap_head: got %h expected %h", obs, exp_state());
        else passed++;
        for (int k = 0; k < 2; k++) begin
            idle(1'b0);
            total++;
            if (obs !== exp_state()) $display("FAIL wrap_drain_%0d: got %h expected %h", k, obs, exp_state());
            else passed++;
        end
    endtask

    task automatic test_flush_priority();
        tick(1'b1, 1'b1, 32'h4000, 32'h4001, 32'h600, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 32'h4002, 32'h4003, 32'h608, 1'b1, 1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL flush_pre: got %h expected %h", obs, exp_state());
        else passed++;
        tick(1'b1, 1'b1, 32'h4004, 32'h4005, 32'h610, 1'b0, 1'b1);
        total++;
        if ({ready_o, valid0_o, valid1_o} !== 3'b100)
            $display("FAIL flush_empty: got %b%b%b expected 100", ready_o, valid0_o, valid1_o);
        else passed++;
        idle(1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL flush_discard: got %h expected %h", obs, exp_state());
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b1, 32'h5000 + 32'(2 * k), 32'h5001 + 32'(2 * k),
                 32'h700 + 32'(8 * k), 1'b0, 1'b0);
            total++;
            if (obs !== exp_state()) $display("FAIL b2b_%0d: got %h expected %h", k, obs, exp_state());
            else passed++;
        end
        idle(1'b0);
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b1, 32'h6000, 32'h6001, 32'h800, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 32'h6002, 32'h6003, 32'h808, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 32'h6004, 32'h6005, 32'h810, 1'b1, 1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL rstmid_pre: got %h expected %h", obs, exp_state());
        else passed++;
        #1 rst_i = 1'b1;
        sb.delete();
        #1;
        total++;
        if (obs !== exp_state()) $display("FAIL rstmid_async: got %h expected %h", obs, exp_state());
        else passed++;
        @(negedge clk) rst_i = 1'b0;
        idle(1'b0);
        total++;
        if (obs !== exp_state()) $display("FAIL rstmid_after: got %h expected %h", obs, exp_state());
        else passed++;
    endtask

    initial begin
        rst_i = 1'b1;
        inst0_i = '0; inst1_i = '0; pc_i = '0;
        valid0_i = 1'b0; valid1_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        #12;
        test_reset();
        test_basic_pair();
        test_odd_issue();
        test_stall_fill();
        test_wrap();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000");
        $fatal(1);
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction queue between the fetch stage and `decode`. It takes up to two 32-bit instructions per cycle from fetch, buffers them in a circular FIFO with their PCs, and presents the two oldest entries to `decode` as an instruction pair. It separates fetch from back-end stalls and drops everything in flight on a branch or jump flush.

## Interface
- `DEPTH`, 8: number of instruction entries. Must be a power of two and ≥ 4.
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: reset. Asynchronous, active-high.
- `inst0_i` input 32: older fetched instruction.
- `inst1_i` input 32: younger fetched instruction.
- `pc_i` input 32: PC of `inst0_i`. `inst1_i` is at `pc_i + 4`.
- `valid0_i` input 1: `inst0_i` is valid.
- `valid1_i` input 1: `inst1_i` is valid. Ignored unless `valid0_i` is high.
- `ready_o` output 1: queue can accept a full pair this cycle.
- `flush_i` input 1: discard all entries and any incoming pair.
- `stall_i` input 1: decode/back-end cannot accept instructions this cycle.
- `inst0_o`, `inst1_o` output 32 each: oldest and second-oldest entries, feeding `decode` `inst0_i`/`inst1_i`.
- `pc0_o`, `pc1_o` output 32 each: PCs of `inst0_o` and `inst1_o`.
- `valid0_o`, `valid1_o` output 1 each: the corresponding output slot holds a real instruction.

## Operation
- **Storage**
  - `DEPTH` entries of {inst, pc}.
  - Head and tail pointers, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - `count`, `$clog2(DEPTH)+1` bits.
- **Ready**
  - `ready_o = (DEPTH - count) >= 2`.
  - Computed from the registered `count` only; same-cycle pops are not credited.
- **Push**
  - A push happens when `valid0_i & ready_o & !flush_i`.
  - It writes `inst0_i`/`pc_i` at the tail.
  - If `valid1_i` is also high, it writes `inst1_i`/`pc_i+4` at tail+1.
  - The tail advances by 1 or 2.
  - Input presented while `ready_o` is low is dropped. Fetch must hold its PC in that case.
- **Outputs (show-ahead, combinational from storage)**
  - `valid0_o = count >= 1`; `valid1_o = count >= 2`.
  - An invalid slot drives inst `32'h00000013` (NOP) and pc 0.
- **Pop**
  - When `!stall_i & !flush_i`, the head advances by `valid0_o + valid1_o`.
  - A single remaining entry issues alone in slot 0.
- **Count update**: `count_next = count + pushes - pops`. Simultaneous push and pop is legal at any occupancy.
- **Flush**
  - Head, tail and count all go to 0 at the next edge.
  - It has priority over push and pop in the same cycle.
- **Reset**
  - Head, tail and count are 0.
  - `valid0_o`/`valid1_o` are 0; `inst0_o`/`inst1_o` are NOP; `pc0_o`/`pc1_o` are 0; `ready_o` is 1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation clears the queue immediately (asynchronously), with the same result as reset from idle.

## Timing
- Enqueue-to-output latency: 1 cycle. A pair pushed at edge N appears on the outputs after edge N.
- Stall hold: while `stall_i` is high, outputs are stable unless `flush_i` or `rst_i` is asserted.
- Throughput: 2 instructions/cycle in steady state.
- `ready_o` is deasserted when `count > DEPTH-2`.
- Wrap-around: an entry at index DEPTH-1 is followed by index 0. This applies when pushing a pair across the boundary and when popping a pair across it.

## Configuration
- `FETCHQ_BYPASS_EN` defined: when `count == 0`, `!stall_i` and `!flush_i`, a valid incoming pair is driven straight to the outputs that cycle (0-cycle latency) and is not written to the queue.
  - If `stall_i` is high, the pair is enqueued normally.
  - Ordering is preserved because bypass happens only when the queue is empty.
- `FETCHQ_BYPASS_EN` undefined: outputs come only from storage, with 1-cycle minimum latency.

## Test plan
- **Reset**: assert `rst_i` mid-stream with count=5 → all valid outputs 0, outputs NOP, `ready_o`=1, count=0 without waiting for a clock edge.
- **Basic pair**: push `inst0=32'h00500093`, `inst1=32'h00A00113`, `pc_i=32'h100`, `stall_i`=0 → next cycle both valids 1, `pc0_o=32'h100`, `pc1_o=32'h104`. The cycle after: valids 0.
- **Odd issue**: push a single instruction (`valid1_i`=0), then a pair → first output cycle `valid0_o`=1, `valid1_o`=0. Second output cycle issues the pair in order.
- **Stall fill**: `stall_i`=1 with pairs pushed every cycle, DEPTH=8 → `ready_o` drops after the 4th pair and dropped inputs are not stored. Releasing the stall drains 8 instructions over 4 cycles in PC order.
- **Wrap**: push 3 pairs, pop 3 pairs, then push 2 pairs → entries at indices 6,7,0,1 come out in correct PC order with no loss.
- **Flush priority**: count=4 with `flush_i`=1, `stall_i`=0 and a valid pair at the input in the same cycle → next cycle count=0, valids 0, and the incoming pair is discarded.
